pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Sequences pipeline freeze, flush and bubble insertion for the five-stage MIPS pipeline. Arbitrates among three stall sources: the hazard detection unit's `hazard_detected`, a taken branch resolved in EXE, and a multi-cycle data-memory handshake from MEM. Drives the enables of the PC and all pipeline registers. Keeps saturating performance counters and a sticky memory-timeout flag.

## Interface

Parameters:
- `CNT_W`, 16: width of the performance counters.
- `TIMEOUT`, 255: MEM_WAIT cycles before `mem_timeout` sets (1..2^CNT_W-1).
- `FLUSH_CYCLES`, 1: IF/ID flush cycles per taken branch (1..4).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hazard_detected`  in  1  load-use/branch/jump hazard from the hazard detection unit.
- `br_taken`  in  1  branch/jump taken, resolved in EXE.
- `mem_req`  in  1  MEM-stage instruction accesses data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `stat_clr`  in  1  synchronous clear of the counters.
- `pc_freeze`  out  1  hold the PC.
- `if_id_freeze`  out  1  hold the IF/ID register.
- `if_id_flush`  out  1  load a NOP into IF/ID.
- `id_exe_bubble`  out  1  load a NOP into ID/EXE.
- `exe_mem_freeze`  out  1  hold the EXE/MEM register.
- `mem_wb_bubble`  out  1  load a NOP into MEM/WB.
- `stall_cnt`  out  CNT_W  cycles with `pc_freeze` high, saturating.
- `flush_cnt`  out  CNT_W  taken branches accepted, saturating.
- `mem_timeout`  out  1  sticky: a memory access exceeded TIMEOUT.

## Operation

- States: RUN, MEM_WAIT, BR_FLUSH. Registers: state, `wait_cnt`, `flush_left`, the two counters, `mem_timeout`.
- Outputs are combinational from the current state and inputs (Mealy), so a stall takes effect in the cycle its cause appears.
- Priority in RUN: memory > branch > hazard.
- RUN, `mem_req && !mem_ready`:
  - Asserts `pc_freeze`, `if_id_freeze`, `exe_mem_freeze`, `mem_wb_bubble`, and `id_exe_bubble=0`. ID/EXE is held: EXE/MEM freeze implies ID/EXE hold, which is wired by the enable of `exe_mem_freeze`.
  - Next state MEM_WAIT; `wait_cnt` is set to 1.
- RUN, `br_taken` (no memory stall):
  - Asserts `if_id_flush` and `id_exe_bubble`. The PC is not frozen because it loads the target.
  - `flush_cnt` increments.
  - If FLUSH_CYCLES>1, next state BR_FLUSH with `flush_left`=FLUSH_CYCLES-1.
- RUN, `hazard_detected` only: asserts `pc_freeze`, `if_id_freeze`, `id_exe_bubble`.
- RUN, `mem_req && mem_ready` in the same cycle: no stall.
- MEM_WAIT:
  - Asserts the same freeze set as RUN's memory stall while `!mem_ready`.
  - On `mem_ready`: all outputs low that cycle, next state RUN. A pending `br_taken`/`hazard_detected` is re-evaluated in RUN next cycle, since EXE/ID held their contents.
  - `br_taken` and `hazard_detected` are ignored in MEM_WAIT.
  - `wait_cnt` increments per cycle, saturating at TIMEOUT. When it equals TIMEOUT with `mem_ready` low, `mem_timeout` sets and stays set until reset. The FSM keeps waiting.
- BR_FLUSH:
  - Asserts `if_id_flush` each cycle; `flush_left` decrements.
  - Next state RUN when `flush_left`==1 is consumed.
  - A `mem_req && !mem_ready` here takes priority: next state MEM_WAIT and the remaining flushes are dropped. A new `br_taken` is impossible because EXE holds a bubble.
- `stall_cnt` increments in every cycle `pc_freeze` is high.
- Both counters saturate at 2^CNT_W-1. `stat_clr` clears them to 0 and wins over a simultaneous increment.

## Timing

- Reset (`rst`=0, asynchronous): state RUN, `wait_cnt`=0, `flush_left`=0, counters 0, `mem_timeout`=0. All outputs are 0 while in reset and with inputs low.
- Stall/flush latency 0 cycles (combinational from inputs). State updates on the rising edge of `clk`.
- Memory handshake: `mem_req` stays high until the cycle `mem_ready` is high. That cycle is the first unfrozen cycle.
- Reset asserted mid-MEM_WAIT or mid-BR_FLUSH aborts to RUN immediately. No flush or stall is carried over.

## Test plan

- Reset, then idle 10 cycles -> all outputs 0, `stall_cnt`=0, `flush_cnt`=0.
- `hazard_detected` high 2 cycles -> `pc_freeze`/`if_id_freeze`/`id_exe_bubble` high exactly 2 cycles, `stall_cnt`=2.
- `mem_req` with `mem_ready` after 3 cycles, `br_taken` and `hazard_detected` high throughout -> freeze set for 3 cycles, branch ignored. After return to RUN, `if_id_flush` is seen next cycle and `flush_cnt`=1.
- FLUSH_CYCLES=3, one-cycle `br_taken` -> `if_id_flush` high 3 consecutive cycles, `id_exe_bubble` only in the first.
- TIMEOUT=4, `mem_ready` held low 6 cycles -> `mem_timeout` rises at the 4th wait cycle and stays high after `mem_ready`, until `rst`.
- CNT_W=4, hold `hazard_detected` 20 cycles -> `stall_cnt` saturates at 15. `stat_clr` together with the stall -> 0.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the five-stage pipeline: arbitrates memory wait, taken
// branch and hazard stalls, drives register enables, keeps saturating statistics.
module pipeline_stall_controller #(
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 255,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             stat_clr,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_bubble,
    output logic             exe_mem_freeze,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam logic [1:0]       ST_RUN      = 2'd0;
    localparam logic [1:0]       ST_MEM_WAIT = 2'd1;
    localparam logic [1:0]       ST_BR_FLUSH = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WAIT_LIMIT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [2:0]       r_flush_left;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_mem_timeout;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic [2:0]       w_flush_left_nxt;
    logic             w_flush_inc;
    logic             w_timeout_set;
    logic             w_mem_stall;
    logic             w_pc_freeze;
    logic             w_if_id_freeze;
    logic             w_if_id_flush;
    logic             w_id_exe_bubble;
    logic             w_mem_freeze;

    assign w_mem_stall = mem_req & ~mem_ready;

    // Mealy arbitration: enables and next-state from current state and inputs
    always_comb begin
        w_state_nxt      = r_state;
        w_wait_nxt       = r_wait_cnt;
        w_flush_left_nxt = r_flush_left;
        w_flush_inc      = 1'b0;
        w_pc_freeze      = 1'b0;
        w_if_id_freeze   = 1'b0;
        w_if_id_flush    = 1'b0;
        w_id_exe_bubble  = 1'b0;
        w_mem_freeze     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_pc_freeze    = 1'b1;
                    w_if_id_freeze = 1'b1;
                    w_mem_freeze   = 1'b1;
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_nxt     = CNT_ONE;
                end else if (br_taken) begin
                    // PC keeps running: it loads the branch target this cycle
                    w_if_id_flush   = 1'b1;
                    w_id_exe_bubble = 1'b1;
                    w_flush_inc     = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt      = ST_BR_FLUSH;
                        w_flush_left_nxt = FLUSH_INIT;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (hazard_detected) begin
                    w_pc_freeze     = 1'b1;
                    w_if_id_freeze  = 1'b1;
                    w_id_exe_bubble = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    w_pc_freeze    = 1'b1;
                    w_if_id_freeze = 1'b1;
                    w_mem_freeze   = 1'b1;
                    w_wait_nxt     = (r_wait_cnt == WAIT_LIMIT) ? r_wait_cnt : r_wait_cnt + CNT_ONE;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            ST_BR_FLUSH: begin
                if (w_mem_stall) begin
                    w_pc_freeze      = 1'b1;
                    w_if_id_freeze   = 1'b1;
                    w_mem_freeze     = 1'b1;
                    w_state_nxt      = ST_MEM_WAIT;
                    w_wait_nxt       = CNT_ONE;
                    w_flush_left_nxt = 3'd0;
                end else begin
                    w_if_id_flush    = 1'b1;
                    w_flush_left_nxt = r_flush_left - 3'd1;
                    if (r_flush_left == 3'd1) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_BR_FLUSH;
                    end
                end
            end
            default: begin
                w_state_nxt      = ST_RUN;
                w_wait_nxt       = '0;
                w_flush_left_nxt = 3'd0;
            end
        endcase
        w_timeout_set = w_mem_freeze & (w_wait_nxt == WAIT_LIMIT);
    end

    // State, wait/flush counters, statistics and sticky timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_flush_left  <= 3'd0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_flush_left <= w_flush_left_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
            if (stat_clr) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_pc_freeze && (r_stall_cnt != CNT_MAX)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_ONE;
                end
                if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
                    r_flush_cnt <= r_flush_cnt + CNT_ONE;
                end
            end
        end
    end

    assign pc_freeze      = w_pc_freeze;
    assign if_id_freeze   = w_if_id_freeze;
    assign if_id_flush    = w_if_id_flush;
    assign id_exe_bubble  = w_id_exe_bubble;
    assign exe_mem_freeze = w_mem_freeze;
    assign mem_wb_bubble  = w_mem_freeze;
    assign stall_cnt      = r_stall_cnt;
    assign flush_cnt      = r_flush_cnt;
    assign mem_timeout    = r_mem_timeout;

endmodule
